// File: rtl/convolutional_encoder.sv
// K=7 rate-1/2 convolutional encoder (g0=133, g1=171 octal) with puncturing to 2/3 and 3/4.
// One input bit at a time; coded bits are emitted serially with a valid/ready handshake.
module convolutional_encoder (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Input,
  input  logic       InValid,
  input  logic       InLast,
  input  logic [1:0] Rate,
  output logic       InReady,
  output logic       Output,
  output logic       OutValid,
  input  logic       OutReady
);

  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;

  state_t      state, state_n;
  logic [5:0]  sr;
  logic [1:0]  phase, rate_q, rate_eff;
  logic        active, last_q, a_p1, b_p1, keep_b_p1;
  logic        accept, a_n, b_n, keep_a, keep_b, done;

  function automatic logic [1:0] norm_rate(input logic [1:0] r);
    return (r == 2'b11) ? 2'b00 : r;
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] r, input logic [1:0] ph);
    case (r)
      2'b01:   return (ph == 2'd1) ? 2'd0 : ph + 2'd1;
      2'b10:   return (ph == 2'd2) ? 2'd0 : ph + 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic keep_a_f(input logic [1:0] r, input logic [1:0] ph);
    return !(r == 2'b10 && ph == 2'd2);
  endfunction

  function automatic logic keep_b_f(input logic [1:0] r, input logic [1:0] ph);
    return !(r != 2'b00 && ph == 2'd1);
  endfunction

  always_comb begin
    InReady  = (state == IDLE);
    accept   = InValid && InReady;
    // Rate is taken live only for the first bit of a frame
    rate_eff = active ? rate_q : norm_rate(Rate);
    a_n      = Input ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
    b_n      = Input ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
    keep_a   = keep_a_f(rate_eff, phase);
    keep_b   = keep_b_f(rate_eff, phase);
    state_n  = state;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_n = keep_a ? EMIT_A : EMIT_B;
      end
      EMIT_A: begin
        if (OutReady) begin
          if (keep_b_p1) begin
            state_n = EMIT_B;
          end else begin
            state_n = IDLE;
            done    = 1'b1;
          end
        end
      end
      EMIT_B: begin
        if (OutReady) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      sr        <= '0;
      phase     <= '0;
      rate_q    <= 2'b00;
      active    <= 1'b0;
      last_q    <= 1'b0;
      a_p1      <= 1'b0;
      b_p1      <= 1'b0;
      keep_b_p1 <= 1'b0;
      Output    <= 1'b0;
      OutValid  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_p1      <= a_n;
        b_p1      <= b_n;
        keep_b_p1 <= keep_b;
        sr        <= {sr[4:0], Input};
        phase     <= next_phase(rate_eff, phase);
        active    <= 1'b1;
        last_q    <= InLast;
        if (!active) rate_q <= norm_rate(Rate);
      end else if (done && last_q) begin
        sr     <= '0;
        phase  <= '0;
        active <= 1'b0;
        last_q <= 1'b0;
      end
      // Output stage: registered copy of the coded bit selected by the next state
      OutValid <= (state_n != IDLE);
      case (state_n)
        EMIT_A:  Output <= accept ? a_n : a_p1;
        EMIT_B:  Output <= accept ? b_n : b_p1;
        default: Output <= 1'b0;
      endcase
    end
  end

endmodule
